instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the 256x16 main memory. Owns the memory address/enable/rw bus,

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_port_mux.sv | 47 ++++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, the opcodes the fetch stage
// has to recognise, and the fetch state encoding.
package cpu_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 16;

  localparam logic [3:0] OP_MOVI = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_JMP  = 4'b0110;

  typedef enum logic [1:0] {
    S_OP,
    S_IMM,
    S_HOLD,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/mem_port_mux.sv
// Memory bus arbiter between the fetch engine and the execute data port.
// A data request always wins the bus for the cycle it is raised, and is
// acknowledged in that same cycle because the memory reads combinationally.
// Ports:
//   bus_en      in  1   bus may be driven (low while in reset)
//   fetch_req   in  1   fetch engine wants a read
//   fetch_addr  in  AW  fetch read address
//   dreq/dwe    in  1   data request / 1=store
//   daddr       in  AW  data address
//   dwdata      in  DW  store data
//   mem_dout    in  DW  memory read data
//   mem_addr/mem_din/mem_rw/mem_en  out  memory bus
//   drdata      out DW  load data (0 unless dack)
//   dack        out 1   data access performed this cycle
module mem_port_mux #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          bus_en,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  input  logic [DW-1:0] mem_dout,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_rw,
  output logic          mem_en,
  output logic [DW-1:0] drdata,
  output logic          dack
);

  logic data_sel;

  always_comb begin
    data_sel = bus_en & dreq;
    dack     = data_sel;
    mem_addr = data_sel ? daddr : fetch_addr;
    mem_din  = data_sel ? dwdata : '0;
    mem_rw   = data_sel & dwe;
    mem_en   = data_sel | (bus_en & fetch_req);
    drdata   = data_sel ? mem_dout : '0;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Reads 2-word instruction slots at even addresses,
// pulls the immediate word for MOVI, and hands instr/imm/pc to decode with a
// valid/ready handshake. Execute's single-cycle data port shares the bus.
// Optional feature macro: ALIGN_CHECK_EN -- an odd redirect target halts the
// stage and raises a sticky align_fault instead of being rounded down.
// Ports:
//   clk, rst (async, active-low)
//   mem_addr/mem_din/mem_rw/mem_en out, mem_dout in   memory bus
//   ir/imm/pc/ir_valid out, ir_ready in               decode handshake
//   redir_valid/redir_pc in                           jump/skip redirect
//   dreq/dwe/daddr/dwdata in, drdata/dack out         execute data port
//   halted, align_fault out                           status
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_rw,
  output logic          mem_en,
  input  logic [DW-1:0] mem_dout,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] imm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dack,
  output logic          halted,
  output logic          align_fault
);

  fetch_state_e  state;
  logic [AW-1:0] fpc;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [3:0]    rd_opcode;

  assign ir_valid   = (state == S_HOLD);
  assign fetch_req  = (state == S_OP) || (state == S_IMM);
  // The immediate sits in the odd word of the slot; wraps modulo 2^AW.
  assign fetch_addr = (state == S_IMM) ? fpc + AW'(1) : fpc;
  assign rd_opcode  = mem_dout[DW-1 -: 4];

`ifdef ALIGN_CHECK_EN
  logic align_fault_q;
  assign align_fault = align_fault_q;
`else
  logic unused_redir_bit0;
  assign align_fault       = 1'b0;
  assign unused_redir_bit0 = redir_pc[0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_OP;
      fpc    <= RESET_PC;
      pc     <= RESET_PC;
      ir     <= '0;
      imm    <= '0;
      halted <= 1'b0;
`ifdef ALIGN_CHECK_EN
      align_fault_q <= 1'b0;
`endif
    end else if (state != S_HALT) begin
      // Redirect beats both the FSM step and a data-port freeze.
      if (redir_valid) begin
`ifdef ALIGN_CHECK_EN
        if (redir_pc[0]) begin
          align_fault_q <= 1'b1;
          halted        <= 1'b1;
          state         <= S_HALT;
        end else begin
          fpc   <= {redir_pc[AW-1:1], 1'b0};
          state <= S_OP;
        end
`else
        fpc   <= {redir_pc[AW-1:1], 1'b0};
        state <= S_OP;
`endif
      end else if (!dreq) begin
        unique case (state)
          S_OP: begin
            ir    <= mem_dout;
            pc    <= fpc;
            imm   <= '0;
            state <= (rd_opcode == OP_MOVI) ? S_IMM : S_HOLD;
          end
          S_IMM: begin
            imm   <= mem_dout;
            state <= S_HOLD;
          end
          S_HOLD: begin
            if (ir_ready) begin
              if (ir[DW-1 -: 4] == OP_HALT) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                fpc   <= fpc + AW'(2);
                state <= S_OP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  mem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .bus_en     (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .dreq       (dreq),
    .dwe        (dwe),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .mem_dout   (mem_dout),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_rw     (mem_rw),
    .mem_en     (mem_en),
    .drdata     (drdata),
    .dack       (dack)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 256x16 memory model, a scoreboard of
// expected decode transfers, and immediate-assertion checks of bus/status.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic        mem_rw, mem_en;
  logic [15:0] ir, imm, pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_pc = '0;
  logic        dreq = 1'b0, dwe = 1'b0;
  logic [15:0] daddr = '0, dwdata = '0;
  logic [15:0] drdata;
  logic        dack, halted, align_fault;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem[256];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        saw_fetch4 = 1'b0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_rw      (mem_rw),
    .mem_en      (mem_en),
    .mem_dout    (mem_dout),
    .ir          (ir),
    .imm         (imm),
    .pc          (pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .dreq        (dreq),
    .dwe         (dwe),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .drdata      (drdata),
    .dack        (dack),
    .halted      (halted),
    .align_fault (align_fault)
  );

  // Memory decodes addr[7:0] and reads combinationally.
  assign mem_dout = mem_en ? mem[mem_addr[7:0]] : 16'h0000;
  always @(posedge clk) if (mem_en && mem_rw) mem[mem_addr[7:0]] = mem_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] m, input logic [15:0] p);
    exp_t e;
    e.ir = i; e.imm = m; e.pc = p;
    exp_q.push_back(e);
  endtask

  // Transfer monitor: inputs only change on the falling edge, so 3 units
  // later everything is settled for the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst && mem_en && !mem_rw && mem_addr == 16'h0004) saw_fetch4 = 1'b1;
    if (rst && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected_ir", {16'h0, ir}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_ir", {16'h0, ir}, {16'h0, e.ir});
        chk("xfer_imm", {16'h0, imm}, {16'h0, e.imm});
        chk("xfer_pc", {16'h0, pc}, {16'h0, e.pc});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halted && k < 30) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk(tag, {31'h0, halted}, 32'h1);
  endtask

  initial begin
    // ---- reset values, plain program ADD; HALT ----
    start_reset();
    mem[0] = 16'h1088; mem[2] = 16'hF000; mem[4] = 16'h1234;
    ir_ready = 1'b1;
    dreq = 1'b1; dwe = 1'b1; daddr = 16'h0010;
    #1;
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_dack", {31'h0, dack}, 32'h0);
    chk("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
    dreq = 1'b0; dwe = 1'b0;
    #1;
    chk("rst_ir", {16'h0, ir}, 32'h0);
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_imm", {16'h0, imm}, 32'h0);
    chk("rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_align", {31'h0, align_fault}, 32'h0);
    push(16'h1088, 16'h0, 16'h0);
    push(16'hF000, 16'h0, 16'h2);
    saw_fetch4 = 1'b0;
    cyc(1); rst = 1'b1; #1;
    chk("p1_first_addr", {16'h0, mem_addr}, 32'h0);
    chk("p1_first_en", {31'h0, mem_en}, 32'h1);
    cyc(1); #1;
    chk("p1_valid_after_op", {31'h0, ir_valid}, 32'h1);
    wait_halt("p1_halted");
    cyc(2); #1;
    chk("p1_halt_no_fetch", {31'h0, mem_en}, 32'h0);
    chk("p1_halt_valid", {31'h0, ir_valid}, 32'h0);
    chk("p1_no_fetch4", {31'h0, saw_fetch4}, 32'h0);
    chk("p1_q_empty", exp_q.size(), 32'h0);

    // ---- MOVI, then hold with ir_ready low ----
    start_reset();
    mem[0] = 16'hC040; mem[1] = 16'h000A; mem[2] = 16'hF000;
    push(16'hC040, 16'h000A, 16'h0);
    cyc(1); rst = 1'b1; #1;
    chk("movi_op_addr", {16'h0, mem_addr}, 32'h0);
    cyc(1); #1;
    chk("movi_not_yet_valid", {31'h0, ir_valid}, 32'h0);
    chk("movi_imm_addr", {16'h0, mem_addr}, 32'h1);
    cyc(1); #1;
    chk("movi_valid", {31'h0, ir_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(1); #1;
      chk("hold_ir", {16'h0, ir}, 32'hC040);
      chk("hold_imm", {16'h0, imm}, 32'h000A);
      chk("hold_pc", {16'h0, pc}, 32'h0);
      chk("hold_mem_en", {31'h0, mem_en}, 32'h0);
    end
    cyc(1);
    ir_ready = 1'b1;
    push(16'hF000, 16'h0, 16'h2);
    cyc(1); #1;
    chk("hold_fpc_plus2", {16'h0, mem_addr}, 32'h2);
    wait_halt("movi_halted");
    chk("movi_q_empty", exp_q.size(), 32'h0);

    // ---- data port: store during S_OP, load while halted ----
    start_reset();
    mem[0] = 16'h1088; mem[2] = 16'hF000;
    ir_ready = 1'b1;
    push(16'h1088, 16'h0, 16'h0);
    push(16'hF000, 16'h0, 16'h2);
    cyc(1);
    rst = 1'b1; dreq = 1'b1; dwe = 1'b1; daddr = 16'h0040; dwdata = 16'hBEEF;
    #1;
    chk("st_dack", {31'h0, dack}, 32'h1);
    chk("st_rw", {31'h0, mem_rw}, 32'h1);
    chk("st_addr", {16'h0, mem_addr}, 32'h40);
    chk("st_din", {16'h0, mem_din}, 32'hBEEF);
    cyc(1); dreq = 1'b0; dwe = 1'b0; #1;
    chk("st_after_dack", {31'h0, dack}, 32'h0);
    chk("st_after_din", {16'h0, mem_din}, 32'h0);
    chk("st_fetch_delayed", {16'h0, mem_addr}, 32'h0);
    chk("st_fetch_rd", {31'h0, mem_en & ~mem_rw}, 32'h1);
    wait_halt("data_halted");
    cyc(1); dreq = 1'b1; dwe = 1'b0; daddr = 16'h0040; #1;
    chk("ld_dack", {31'h0, dack}, 32'h1);
    chk("ld_data", {16'h0, drdata}, 32'hBEEF);
    cyc(1); dreq = 1'b0; #1;
    chk("ld_idle_drdata", {16'h0, drdata}, 32'h0);
    chk("data_q_empty", exp_q.size(), 32'h0);

    // ---- redirect during S_IMM ----
    start_reset();
    mem[0] = 16'hC040; mem[1] = 16'h00AA; mem[12] = 16'hF000;
    ir_ready = 1'b1;
    cyc(1); rst = 1'b1;
    cyc(1); redir_valid = 1'b1; redir_pc = 16'h000C; #1;
    chk("rd_in_imm", {16'h0, mem_addr}, 32'h1);
    push(16'hF000, 16'h0, 16'h000C);
    cyc(1); redir_valid = 1'b0; #1;
    chk("rd_valid_dropped", {31'h0, ir_valid}, 32'h0);
    chk("rd_target", {16'h0, mem_addr}, 32'hC);
    wait_halt("rd_halted");
    chk("rd_pc", {16'h0, pc}, 32'hC);
    chk("rd_q_empty", exp_q.size(), 32'h0);

    // ---- odd redirect target ----
    start_reset();
    mem[0] = 16'h1088; mem[6] = 16'hF000;
    cyc(1); rst = 1'b1;
    cyc(1); redir_valid = 1'b1; redir_pc = 16'h0007; #1;
    chk("odd_pre_valid", {31'h0, ir_valid}, 32'h1);
    cyc(1); redir_valid = 1'b0; #1;
`ifdef ALIGN_CHECK_EN
    chk("odd_fault", {31'h0, align_fault}, 32'h1);
    chk("odd_halted", {31'h0, halted}, 32'h1);
    chk("odd_no_fetch", {31'h0, mem_en}, 32'h0);
    redir_valid = 1'b1; redir_pc = 16'h0000;
    cyc(1); redir_valid = 1'b0; #1;
    chk("odd_redir_ignored", {31'h0, mem_en}, 32'h0);
    chk("odd_sticky", {31'h0, align_fault}, 32'h1);
`else
    chk("odd_no_fault", {31'h0, align_fault}, 32'h0);
    chk("odd_target6", {16'h0, mem_addr}, 32'h6);
    chk("odd_fetching", {31'h0, mem_en}, 32'h1);
    push(16'hF000, 16'h0, 16'h6);
    ir_ready = 1'b1;
    wait_halt("odd_halted");
    chk("odd_q_empty", exp_q.size(), 32'h0);
`endif

    // ---- MOVI at 16'hFFFE, wrap to 0 ----
    start_reset();
    mem[0] = 16'h1088; mem[2] = 16'hF000; mem[8'hFE] = 16'hC040; mem[8'hFF] = 16'h0055;
    cyc(1); rst = 1'b1;
    cyc(1); redir_valid = 1'b1; redir_pc = 16'hFFFE;
    cyc(1); redir_valid = 1'b0; #1;
    chk("wrap_op_addr", {16'h0, mem_addr}, 32'hFFFE);
    cyc(1); #1;
    chk("wrap_imm_addr", {16'h0, mem_addr}, 32'hFFFF);
    push(16'hC040, 16'h0055, 16'hFFFE);
    push(16'h1088, 16'h0, 16'h0);
    push(16'hF000, 16'h0, 16'h2);
    ir_ready = 1'b1;
    wait_halt("wrap_halted");
    chk("wrap_q_empty", exp_q.size(), 32'h0);

    // ---- reset mid-fetch ----
    start_reset();
    mem[0] = 16'hC040; mem[1] = 16'h1234;
    cyc(1); rst = 1'b1;
    cyc(1); #1;
    chk("mid_ir_loaded", {16'h0, ir}, 32'hC040);
    rst = 1'b0; #1;
    chk("mid_ir", {16'h0, ir}, 32'h0);
    chk("mid_imm", {16'h0, imm}, 32'h0);
    chk("mid_pc", {16'h0, pc}, 32'h0);
    chk("mid_valid", {31'h0, ir_valid}, 32'h0);
    chk("mid_mem_en", {31'h0, mem_en}, 32'h0);
    chk("mid_halted", {31'h0, halted}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
